// File: rtl/cic_interp.sv
// rtl/cic_interp.sv - N-stage CIC interpolator, upsampling by R with valid/ready sample intake
module cic_interp #(
    parameter int IN_W  = 11,
    parameter int R     = 8,
    parameter int N     = 3,
    parameter int M     = 1,
    parameter int IW    = IN_W + N * $clog2(R * M),
    parameter int OUT_W = IW - $clog2(R)
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    en_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic signed [IN_W-1:0]  data_i,
    output logic                    valid_o,
    output logic signed [OUT_W-1:0] data_o,
    output logic                    underflow_o
);

    localparam int PW = $clog2(R);

    logic        [PW-1:0] ph;
    logic        [N:0]    vsr;
    logic signed [IN_W-1:0] x;
    logic signed [IW-1:0] c     [0:N];
    logic signed [IW-1:0] dly   [1:N][0:M-1];
    logic signed [IW-1:0] integ [1:N];
    logic signed [IW-1:0] up_r;
    logic                 unused_hi;

    assign in_ready_o = en_i && (ph == '0);
    assign x          = in_valid_i ? data_i : '0;

    // Comb section sees the new sample and the oldest entry of each delay line.
    always_comb begin
        c[0] = {{(IW - IN_W){x[IN_W-1]}}, x};
        for (int k = 1; k <= N; k++) begin
            c[k] = c[k-1] - dly[k][M-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            ph          <= '0;
            up_r        <= '0;
            vsr         <= '0;
            underflow_o <= 1'b0;
            for (int k = 1; k <= N; k++) begin
                integ[k] <= '0;
                for (int j = 0; j < M; j++) begin
                    dly[k][j] <= '0;
                end
            end
        end else if (en_i) begin
            ph   <= (ph == PW'(R - 1)) ? '0 : ph + 1'b1;
            up_r <= in_ready_o ? c[N] : '0;
            if (in_ready_o) begin
                for (int k = 1; k <= N; k++) begin
                    dly[k][0] <= c[k-1];
                    for (int j = 1; j < M; j++) begin
                        dly[k][j] <= dly[k][j-1];
                    end
                end
                if (!in_valid_i) begin
                    underflow_o <= 1'b1;
                end
            end
            // Integrators wrap modulo 2^IW; the comb differences cancel the wrap exactly.
            integ[1] <= integ[1] + up_r;
            for (int k = 2; k <= N; k++) begin
                integ[k] <= integ[k] + integ[k-1];
            end
            vsr <= {vsr[N-1:0], 1'b1};
        end
    end

    assign data_o    = integ[N][OUT_W-1:0];
    assign valid_o   = en_i && vsr[N];
    assign unused_hi = ^integ[N][IW-1:OUT_W];

endmodule

// File: tb/tb_cic_interp.sv
// tb/tb_cic_interp.sv - directed and model-based bench for cic_interp at default parameters
module tb_cic_interp;

    logic               clk = 1'b0;
    logic               rstn_i = 1'b0;
    logic               en_i = 1'b0;
    logic               in_valid_i = 1'b0;
    logic               in_ready_o;
    logic signed [10:0] data_i = '0;
    logic               valid_o;
    logic signed [16:0] data_o;
    logic               underflow_o;

    cic_interp dut (
        .clk_i       (clk),
        .rstn_i      (rstn_i),
        .en_i        (en_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .data_i      (data_i),
        .valid_o     (valid_o),
        .data_o      (data_o),
        .underflow_o (underflow_o)
    );

    always #5 clk = ~clk;

    // High-rate impulse response: three cascaded length-8 boxcars.
    int h [0:21] = '{1, 3, 6, 10, 15, 21, 28, 36, 42, 46, 48,
                     48, 46, 42, 36, 28, 21, 15, 10, 6, 3, 1};

    int nvec = 0;
    int nmis = 0;
    int xs [0:1999];
    int nsamp = 0;

    typedef struct {
        bit en;
        bit vld;
        int din;
        bit exp_rdy;
        bit exp_vld;
        int exp_dat;
    } vec_t;

    typedef struct {
        int din;
        int exp_dat;
    } dc_t;

    vec_t tbl [0:31];
    dc_t  dct [0:2];

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Convolution of the zero-stuffed stream with h; output of enabled edge e.
    function automatic int model_y(input int e);
        int s = 0;
        for (int t = 0; t < 22; t++) begin
            int n = e - 3 - t;
            if (n >= 0 && n % 8 == 0 && n / 8 < nsamp) s += xs[n/8] * h[t];
        end
        return s;
    endfunction

    task automatic do_reset(input bit check);
        @(negedge clk);
        rstn_i = 1'b0; en_i = 1'b1; in_valid_i = 1'b1; data_i = 11'sd5;
        @(posedge clk);
        #1;
        if (check) begin
            chk("reset data_o", int'(data_o), 0);
            chk("reset valid_o", int'(valid_o), 0);
            chk("reset underflow_o", int'(underflow_o), 0);
        end
        rstn_i = 1'b1;
    endtask

    task automatic step(input bit en, input bit vld, input int d, output bit rdy);
        @(negedge clk);
        en_i = en; in_valid_i = vld; data_i = d[10:0];
        #1 rdy = in_ready_o;
        @(posedge clk);
        #1;
    endtask

    task automatic run_stream(input bit gaps);
        int  e = 0;
        bit  rdy;
        int  d;
        do_reset(1'b0);
        while (e < nsamp * 8 + 30) begin
            if (gaps && $urandom_range(0, 15) == 0) begin
                int len = int'($urandom_range(1, 20));
                for (int g = 0; g < len; g++) begin
                    step(1'b0, 1'b1, int'($urandom_range(0, 2047)) - 1024, rdy);
                    chk("gap in_ready_o", int'(rdy), 0);
                    chk("gap valid_o", int'(valid_o), 0);
                    chk("gap data_o hold", int'(data_o), model_y(e - 1));
                end
            end
            d = (e / 8 < nsamp) ? xs[e/8] : 0;
            step(1'b1, 1'b1, d, rdy);
            chk("stream in_ready_o", int'(rdy), int'(e % 8 == 0));
            chk("stream valid_o", int'(valid_o), int'(e >= 3));
            chk("stream data_o", int'(data_o), model_y(e));
            e++;
        end
        chk("stream underflow_o", int'(underflow_o), 0);
    endtask

    initial begin
        bit rdy;
        int sum;

        for (int c = 0; c < 32; c++) begin
            tbl[c].en      = 1'b1;
            tbl[c].vld     = (c % 8 == 0);
            tbl[c].din     = (c == 0) ? 1 : 0;
            tbl[c].exp_rdy = (c % 8 == 0);
            tbl[c].exp_vld = (c >= 3);
            tbl[c].exp_dat = (c >= 3 && c - 3 <= 21) ? h[c-3] : 0;
        end
        dct[0] = '{1, 64};
        dct[1] = '{-1024, -65536};
        dct[2] = '{1023, 65472};

        // Impulse response
        do_reset(1'b1);
        chk("reset in_ready_o", int'(in_ready_o), 1);
        sum = 0;
        for (int c = 0; c < 32; c++) begin
            step(tbl[c].en, tbl[c].vld, tbl[c].din, rdy);
            chk("impulse in_ready_o", int'(rdy), int'(tbl[c].exp_rdy));
            chk("impulse valid_o", int'(valid_o), int'(tbl[c].exp_vld));
            chk("impulse data_o", int'(data_o), tbl[c].exp_dat);
            if (valid_o) sum += int'(data_o);
        end
        chk("impulse sum", sum, 512);
        chk("impulse underflow_o", int'(underflow_o), 0);

        // DC steps, including both input extremes
        for (int i = 0; i < 3; i++) begin
            do_reset(1'b0);
            for (int c = 0; c < 40; c++) step(1'b1, 1'b1, dct[i].din, rdy);
            for (int c = 0; c < 8; c++) begin
                step(1'b1, 1'b1, dct[i].din, rdy);
                chk("dc data_o", int'(data_o), dct[i].exp_dat);
                chk("dc valid_o", int'(valid_o), 1);
            end
        end

        // Samples offered only off-slot are ignored and the slot underflows
        do_reset(1'b0);
        for (int c = 0; c < 24; c++) begin
            step(1'b1, (c % 8 != 0), 500, rdy);
            chk("offslot data_o", int'(data_o), 0);
            chk("offslot underflow_o", int'(underflow_o), 1);
        end

        // Mid-stream reset at phase 5 with an active response and underflow set
        do_reset(1'b0);
        step(1'b1, 1'b1, 300, rdy);
        for (int c = 1; c < 13; c++) step(1'b1, 1'b0, 0, rdy);
        chk("pre-reset data_o", int'(data_o), 13800);
        chk("pre-reset underflow_o", int'(underflow_o), 1);
        @(negedge clk);
        rstn_i = 1'b0; en_i = 1'b1; in_valid_i = 1'b1; data_i = 11'sd777;
        @(posedge clk);
        #1;
        chk("midreset data_o", int'(data_o), 0);
        chk("midreset valid_o", int'(valid_o), 0);
        chk("midreset underflow_o", int'(underflow_o), 0);
        rstn_i = 1'b1;
        for (int c = 0; c < 11; c++) begin
            step(1'b1, 1'b1, (c == 0) ? 2 : 0, rdy);
            chk("release in_ready_o", int'(rdy), int'(c % 8 == 0));
            chk("release valid_o", int'(valid_o), int'(c >= 3));
            chk("release data_o", int'(data_o), (c >= 3) ? 2 * h[c-3] : 0);
        end

        // Random full-scale stream against the convolution model
        nsamp = 2000;
        for (int k = 0; k < nsamp; k++) xs[k] = int'($urandom_range(0, 2047)) - 1024;
        run_stream(1'b0);

        // Sine stream with and without random enable gaps
        nsamp = 64;
        for (int k = 0; k < nsamp; k++) xs[k] = $rtoi(1000.0 * $sin(6.283185307 * k / 16.0));
        run_stream(1'b0);
        run_stream(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
